// File: rtl/rx_link_sequencer.sv
// Purpose : receive-link bring-up. Qualifies a live stream, bitslips to the comma, confirms lock, reports link-up.
// Latency : decisions use the word sampled at the same rck edge that updates state; outputs registered.
// Backpres: none. One word is consumed every rck cycle; words are ignored during the post-slip settle window.
//
// Ports:
//   rck           receive word clock (only clock)
//   rst_b         asynchronous active-low reset
//   rx_data       10-bit parallel word from the SERDES
//   rx_bitslip    one-cycle pulse asking the SERDES to shift the word boundary by one bit
//   link_up       high while LOCKED
//   stream_start  one-cycle pulse on entry to LOCKED
//   state         IDLE=0 SEARCH=1 SLIPW=2 VERIFY=3 LOCKED=4
//   slip_pos      current bit offset, 0-9
//   relock_count  LOCKED->IDLE losses, saturating at 255
//   align_timeout one-cycle pulse when alignment gives up (only with RX_LINK_TIMEOUT_EN)
//
// Build option: define RX_LINK_TIMEOUT_EN to bound the alignment search to TIMEOUT cycles.
module rx_link_sequencer #(
  parameter logic [9:0]  ALIGN_PATTERN = 10'b0101111100,
  parameter int unsigned LOCK_COUNT    = 8,
  parameter int unsigned ERR_LIMIT     = 4,
  parameter int unsigned SLIP_WAIT     = 4,
  parameter int unsigned TIMEOUT       = 1023
) (
  input  logic       rck,
  input  logic       rst_b,
  input  logic [9:0] rx_data,
  output logic       rx_bitslip,
  output logic       link_up,
  output logic       stream_start,
  output logic [2:0] state,
  output logic [3:0] slip_pos,
  output logic [7:0] relock_count,
  output logic       align_timeout
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEARCH = 3'd1,
    SLIPW  = 3'd2,
    VERIFY = 3'd3,
    LOCKED = 3'd4
  } state_t;

  // Counters compare against "limit - 1" before incrementing, so the
  // transition fires on the word that makes the count reach the limit.
  localparam logic [7:0] LOCK_LAST = 8'(LOCK_COUNT - 1);
  localparam logic [3:0] ERR_LAST  = 4'(ERR_LIMIT - 1);
  localparam logic [3:0] WAIT_LAST = 4'(SLIP_WAIT - 1);

  state_t     state_q;
  logic [7:0] vcnt;
  logic [3:0] ecnt;
  logic [3:0] wcnt;
  // Live-word tracker: prev_live is the older stage, the word being
  // sampled is the newer stage; both live means the stream is active.
  logic       prev_live;

  logic       is_static;
  logic       is_comma;
  logic       to_hit;

  assign is_static = (rx_data[6:0] == 7'h00) || (rx_data[6:0] == 7'h7F);
  assign is_comma  = (rx_data == ALIGN_PATTERN) || (rx_data == ~ALIGN_PATTERN);
  assign state     = state_q;

`ifdef RX_LINK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tcnt;
  logic          in_align;

  assign in_align = (state_q == SEARCH) || (state_q == SLIPW) || (state_q == VERIFY);
  assign to_hit   = in_align && (tcnt == TO_LAST);
`else
  assign to_hit        = 1'b0;
  assign align_timeout = 1'b0;
`endif

  always_ff @(posedge rck or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= IDLE;
      rx_bitslip   <= 1'b0;
      link_up      <= 1'b0;
      stream_start <= 1'b0;
      slip_pos     <= 4'd0;
      relock_count <= 8'd0;
      vcnt         <= 8'd0;
      ecnt         <= 4'd0;
      wcnt         <= 4'd0;
      prev_live    <= 1'b0;
`ifdef RX_LINK_TIMEOUT_EN
      tcnt          <= '0;
      align_timeout <= 1'b0;
`endif
    end else begin
      rx_bitslip   <= 1'b0;
      stream_start <= 1'b0;
`ifdef RX_LINK_TIMEOUT_EN
      align_timeout <= 1'b0;
      // Runs through SEARCH/SLIPW/VERIFY (including VERIFY->SEARCH
      // fallbacks) and restarts whenever IDLE or LOCKED is reached.
      if (in_align && !to_hit) tcnt <= tcnt + 1'b1;
      else                     tcnt <= '0;
`endif
      if (to_hit) begin
        // Timeout wins over any same-cycle lock decision.
        state_q   <= IDLE;
        slip_pos  <= 4'd0;
        vcnt      <= 8'd0;
        wcnt      <= 4'd0;
        prev_live <= 1'b0;
`ifdef RX_LINK_TIMEOUT_EN
        align_timeout <= 1'b1;
`endif
      end else begin
        case (state_q)
          IDLE: begin
            if (is_static) begin
              prev_live <= 1'b0;
            end else if (prev_live) begin
              prev_live <= 1'b0;
              state_q   <= SEARCH;
            end else begin
              prev_live <= 1'b1;
            end
          end

          SEARCH: begin
            if (is_comma) begin
              if (LOCK_LAST == 8'd0) begin
                state_q      <= LOCKED;
                link_up      <= 1'b1;
                stream_start <= 1'b1;
                ecnt         <= 4'd0;
              end else begin
                state_q <= VERIFY;
                vcnt    <= 8'd1;
              end
            end else begin
              rx_bitslip <= 1'b1;
              slip_pos   <= (slip_pos == 4'd9) ? 4'd0 : slip_pos + 4'd1;
              wcnt       <= 4'd0;
              state_q    <= SLIPW;
            end
          end

          // The SERDES needs time to settle after a slip; data is not looked at.
          SLIPW: begin
            if (wcnt == WAIT_LAST) begin
              wcnt    <= 4'd0;
              state_q <= SEARCH;
            end else begin
              wcnt <= wcnt + 4'd1;
            end
          end

          VERIFY: begin
            if (is_comma) begin
              if (vcnt == LOCK_LAST) begin
                vcnt         <= 8'd0;
                state_q      <= LOCKED;
                link_up      <= 1'b1;
                stream_start <= 1'b1;
                ecnt         <= 4'd0;
              end else begin
                vcnt <= vcnt + 8'd1;
              end
            end else begin
              // A broken run re-searches at the current offset without slipping.
              vcnt    <= 8'd0;
              state_q <= SEARCH;
            end
          end

          LOCKED: begin
            if (is_static) begin
              if (ecnt == ERR_LAST) begin
                ecnt      <= 4'd0;
                state_q   <= IDLE;
                link_up   <= 1'b0;
                slip_pos  <= 4'd0;
                prev_live <= 1'b0;
                if (relock_count != 8'hFF) relock_count <= relock_count + 8'd1;
              end else begin
                ecnt <= ecnt + 4'd1;
              end
            end else begin
              ecnt <= 4'd0;
            end
          end

          default: begin
            state_q <= IDLE;
            link_up <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_link_sequencer.sv
module tb_rx_link_sequencer;

  localparam logic [9:0] COMMA  = 10'b0101111100;
  localparam int         LOCK_N = 8;
  localparam int         ERR_N  = 4;
  localparam int         WAIT_N = 4;
  localparam int         TO_N   = 50;
`ifdef RX_LINK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       rck = 1'b0;
  logic       rst_b = 1'b0;
  logic [9:0] rx_data = 10'h000;
  logic       rx_bitslip, link_up, stream_start, align_timeout;
  logic [2:0] state;
  logic [3:0] slip_pos;
  logic [7:0] relock_count;

  rx_link_sequencer #(
    .ALIGN_PATTERN(COMMA),
    .LOCK_COUNT   (LOCK_N),
    .ERR_LIMIT    (ERR_N),
    .SLIP_WAIT    (WAIT_N),
    .TIMEOUT      (TO_N)
  ) dut (
    .rck          (rck),
    .rst_b        (rst_b),
    .rx_data      (rx_data),
    .rx_bitslip   (rx_bitslip),
    .link_up      (link_up),
    .stream_start (stream_start),
    .state        (state),
    .slip_pos     (slip_pos),
    .relock_count (relock_count),
    .align_timeout(align_timeout)
  );

  always #5 rck = ~rck;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: phase code, run lengths and countdowns.
  int   m_state, m_slip, m_relock;
  int   live_run, wait_left, comma_run, static_run, align_cycles;
  logic e_bitslip, e_link, e_start, e_to;

  // SERDES model: the word boundary sits ser_off bits from alignment;
  // every bitslip moves it one bit closer.
  int ser_off = 3;
  int ser_slips = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] rotl(input logic [9:0] x, input int k);
    logic [19:0] d;
    d = {x, x} << k;
    return d[19:10];
  endfunction

  function automatic logic [9:0] serdes_word();
    int k;
    k = (((ser_off - ser_slips) % 10) + 10) % 10;
    return rotl(COMMA, k);
  endfunction

  task automatic model_reset();
    m_state = 0; m_slip = 0; m_relock = 0;
    live_run = 0; wait_left = 0; comma_run = 0; static_run = 0; align_cycles = 0;
    e_bitslip = 1'b0; e_link = 1'b0; e_start = 1'b0; e_to = 1'b0;
  endtask

  task automatic enter_lock();
    m_state = 4; e_link = 1'b1; e_start = 1'b1; static_run = 0; align_cycles = 0;
  endtask

  task automatic model_step(input logic [9:0] w);
    bit st, cm;
    st = (w[6:0] == 7'h00) || (w[6:0] == 7'h7F);
    cm = (w == COMMA) || (w == ~COMMA);
    e_bitslip = 1'b0; e_start = 1'b0; e_to = 1'b0;
    if (TO_EN && m_state >= 1 && m_state <= 3) begin
      align_cycles++;
      if (align_cycles == TO_N) begin
        m_state = 0; m_slip = 0; live_run = 0; comma_run = 0; align_cycles = 0;
        e_to = 1'b1;
        return;
      end
    end
    case (m_state)
      0: begin
        align_cycles = 0;
        if (st) live_run = 0; else live_run++;
        if (live_run == 2) begin live_run = 0; m_state = 1; end
      end
      1: begin
        if (cm) begin
          comma_run = 1;
          if (comma_run == LOCK_N) enter_lock(); else m_state = 3;
        end else begin
          e_bitslip = 1'b1;
          m_slip = (m_slip + 1) % 10;
          wait_left = WAIT_N;
          m_state = 2;
        end
      end
      2: begin
        wait_left--;
        if (wait_left == 0) m_state = 1;
      end
      3: begin
        if (cm) begin
          comma_run++;
          if (comma_run == LOCK_N) enter_lock();
        end else begin
          comma_run = 0; m_state = 1;
        end
      end
      default: begin
        if (st) static_run++; else static_run = 0;
        if (static_run == ERR_N) begin
          m_state = 0; e_link = 1'b0; m_slip = 0; live_run = 0; static_run = 0;
          if (m_relock < 255) m_relock++;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    check("state", state, m_state);
    check("rx_bitslip", rx_bitslip, e_bitslip);
    check("link_up", link_up, e_link);
    check("stream_start", stream_start, e_start);
    check("slip_pos", slip_pos, m_slip);
    check("relock_count", relock_count, m_relock);
    check("align_timeout", align_timeout, e_to);
  endtask

  // Word already positioned at a negedge: clock it in, model it, compare.
  task automatic drive_and_sample(input logic [9:0] w);
    rx_data = w;
    @(posedge rck);
    model_step(w);
    cyc++;
    #1;
    compare_all();
    if (rx_bitslip === 1'b1) ser_slips++;
  endtask

  task automatic step(input logic [9:0] w);
    @(negedge rck);
    drive_and_sample(w);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, state, 0);
    check({tag, "_bitslip"}, rx_bitslip, 0);
    check({tag, "_link"}, link_up, 0);
    check({tag, "_start"}, stream_start, 0);
    check({tag, "_slip"}, slip_pos, 0);
    check({tag, "_relock"}, relock_count, 0);
    check({tag, "_timeout"}, align_timeout, 0);
  endtask

  int slip_cyc[0:15];
  int nslip, nstart, sc, tc, mode, r;
  logic [9:0] w;

  initial begin
    model_reset();
    // Power-up reset.
    #1;
    check_all_zero("reset");
    @(negedge rck);
    rst_b = 1'b1;
    drive_and_sample(10'h000);

    // Static stream never leaves IDLE.
    for (int i = 0; i < 19; i++) step(10'h000);
    check("static_idle", state, 0);

    // Comma stream 3 bits off: three slips, then lock.
    nslip = 0; nstart = 0;
    for (int i = 0; i < 40; i++) begin
      step(serdes_word());
      if (rx_bitslip === 1'b1 && nslip < 16) begin slip_cyc[nslip] = cyc; nslip++; end
      if (stream_start === 1'b1) nstart++;
    end
    check("slip_pulses", nslip, 3);
    for (int i = 0; i + 1 < nslip && i < 15; i++)
      check("slip_spacing", slip_cyc[i+1] - slip_cyc[i], WAIT_N + 1);
    check("start_pulses", nstart, 1);
    check("lock_link", link_up, 1);
    check("lock_slip_pos", slip_pos, 3);

    // Loss of signal: 3 static, 1 live, 4 static.
    for (int i = 0; i < 3; i++) step(10'h000);
    check("hold_after_3", link_up, 1);
    step(COMMA);
    for (int i = 0; i < 3; i++) step(10'h000);
    check("hold_again", link_up, 1);
    step(10'h000);
    check("loss_link", link_up, 0);
    check("loss_state", state, 0);
    check("loss_relock", relock_count, 1);

    // VERIFY broken by a non-comma after 5 commas.
    step(serdes_word());
    step(serdes_word());
    check("redetect", state, 1);
    for (int i = 0; i < 5; i++) step(serdes_word());
    check("verify_5", state, 3);
    step(10'h2AA);
    check("verify_break_state", state, 1);
    check("verify_break_noslip", rx_bitslip, 0);
    for (int i = 0; i < LOCK_N - 1; i++) step(serdes_word());
    check("relock_pending", link_up, 0);
    step(serdes_word());
    check("relock_link", link_up, 1);
    check("relock_start", stream_start, 1);

    // Drop the link, misalign, and reset in the middle of a slip wait.
    for (int i = 0; i < ERR_N; i++) step(10'h000);
    check("second_loss", relock_count, 2);
    ser_off = (ser_slips + 4) % 10;
    step(serdes_word());
    step(serdes_word());
    step(serdes_word());
    check("slipw_entry", state, 2);
    step(serdes_word());
    #1;
    rst_b = 1'b0;
    #1;
    model_reset();
    check_all_zero("midreset");
    @(negedge rck);
    rst_b = 1'b1;
    drive_and_sample(serdes_word());
    check("fresh_detect_1", state, 0);
    step(serdes_word());
    check("fresh_detect_2", state, 1);

`ifdef RX_LINK_TIMEOUT_EN
    // Non-comma live data times out TO_N cycles after SEARCH is entered.
    @(negedge rck);
    rst_b = 1'b0;
    #1;
    model_reset();
    @(negedge rck);
    rst_b = 1'b1;
    sc = -1; tc = -1;
    drive_and_sample(10'h2AA);
    for (int i = 0; i < 120; i++) begin
      step(10'h2AA);
      if (sc < 0 && state == 3'd1) sc = cyc;
      if (tc < 0 && align_timeout === 1'b1) tc = cyc;
    end
    check("timeout_delay", tc - sc, TO_N);
`endif

    // Randomised segments checked cycle by cycle against the model.
    for (int seg = 0; seg < 75; seg++) begin
      mode = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) ser_off = $urandom_range(0, 9);
      for (int i = 0; i < 20; i++) begin
        r = $urandom_range(0, 99);
        if (mode <= 1) begin
          w = (r < 94) ? serdes_word() : 10'($urandom);
        end else if (mode == 2) begin
          if (r < 50)      w = serdes_word();
          else if (r < 70) w = {3'($urandom), (r[0] ? 7'h7F : 7'h00)};
          else if (r < 90) w = 10'($urandom);
          else             w = 10'h2AA;
        end else begin
          w = (r < 70) ? {3'($urandom), (r[0] ? 7'h7F : 7'h00)} : serdes_word();
        end
        step(w);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
